sum_accumulator: RTL and testbench

- Downstream consumer of the combinational adder stage's WIDTH-bit sum.
- Accepts one sum per cycle over a valid/ready handshake and accumulates a batch of up to COUNT sums into a wider register.
- Presents the batch total with its own valid/ready handshake.
- Turns the single-cycle adder into a multi-cycle reduction stage.

---
 rtl/sum_accumulator_if.sv | 26 ++
 rtl/sum_accumulator.sv | 103 ++++++++++
 tb/tb_sum_accumulator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: upstream sum beats in, batch totals out.
// master drives the IN_* side (producer/consumer), slave is the accumulator.
interface sum_accumulator_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = WIDTH + 4
);
  logic             IN_valid;
  logic             OUT_ready;
  logic [WIDTH-1:0] IN_sum;
  logic             IN_last;
  logic             OUT_valid;
  logic             IN_ready;
  logic [ACC_W-1:0] OUT_total;
  logic [7:0]       OUT_count;
  logic             OUT_ovf;

  modport master (
    output IN_valid, IN_sum, IN_last, IN_ready,
    input  OUT_ready, OUT_valid, OUT_total, OUT_count, OUT_ovf
  );

  modport slave (
    input  IN_valid, IN_sum, IN_last, IN_ready,
    output OUT_ready, OUT_valid, OUT_total, OUT_count, OUT_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Batches up to COUNT upstream sums into an ACC_W-bit total with valid/ready on both sides.
// Define SUM_ACCUMULATOR_SATURATE_EN to clamp on carry-out instead of wrapping.
module sum_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = WIDTH + 4
) (
  input logic              IN_clk,
  input logic              IN_rst_n,
  sum_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_out_q, ovf_out_d;

  logic             accept;
  logic [ACC_W-1:0] base_acc;
  logic [7:0]       base_cnt;
  logic             base_ovf;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             batch_end;

  // Ready is masked by reset so nothing is offered while reset is held.
  assign bus.OUT_ready = IN_rst_n & (state_q != StDone);
  assign bus.OUT_valid = (state_q == StDone);
  assign bus.OUT_total = total_q;
  assign bus.OUT_count = count_q;
  assign bus.OUT_ovf   = ovf_out_q;
  assign accept        = bus.IN_valid & bus.OUT_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    total_d   = total_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;

    // A beat in IDLE starts a fresh batch, so it adds onto zero.
    base_acc  = (state_q == StIdle) ? '0 : acc_q;
    base_cnt  = (state_q == StIdle) ? 8'd0 : cnt_q;
    base_ovf  = (state_q == StIdle) ? 1'b0 : ovf_q;
    sum_ext   = {1'b0, base_acc} + {{(ACC_W + 1 - WIDTH){1'b0}}, bus.IN_sum};
    carry     = sum_ext[ACC_W];
    batch_end = bus.IN_last | ((base_cnt + 8'd1) == 8'(COUNT));

    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
          acc_d = carry ? '1 : sum_ext[ACC_W-1:0];
`else
          acc_d = sum_ext[ACC_W-1:0];
`endif
          cnt_d = base_cnt + 8'd1;
          ovf_d = base_ovf | carry;
          if (batch_end) begin
            state_d   = StDone;
            total_d   = acc_d;
            count_d   = cnt_d;
            ovf_out_d = ovf_d;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StDone: begin
        if (bus.IN_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= 8'd0;
      ovf_q     <= 1'b0;
      total_q   <= '0;
      count_q   <= 8'd0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      total_q   <= total_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed scoreboard bench for sum_accumulator (WIDTH=8, COUNT=4, ACC_W=8).
// Expected batch results are queued at stimulus time and popped by a separate monitor.
module tb_sum_accumulator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned COUNT = 4;
  localparam int unsigned ACC_W = 8;

  typedef struct packed {
    logic [ACC_W-1:0] total;
    logic [7:0]       count;
    logic             ovf;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  res_t exp_q[$];
  res_t mon_e;

  sum_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  sum_accumulator #(
    .WIDTH(WIDTH),
    .COUNT(COUNT),
    .ACC_W(ACC_W)
  ) dut (
    .IN_clk  (clk),
    .IN_rst_n(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int total, input int count, input logic ovf);
    res_t r;
    r.total = ACC_W'(total);
    r.count = 8'(count);
    r.ovf   = ovf;
    exp_q.push_back(r);
  endtask

  // Presents one beat and returns 1ns after the edge that accepted it.
  task automatic beat(input logic [WIDTH-1:0] s, input logic l);
    bit ok;
    bus.IN_valid = 1'b1;
    bus.IN_sum   = s;
    bus.IN_last  = l;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.OUT_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.IN_valid = 1'b0;
    bus.IN_last  = 1'b0;
    bus.IN_sum   = 'x;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus.OUT_valid), 0);
    chk({tag, "_ready"}, int'(bus.OUT_ready), 0);
    chk({tag, "_total"}, int'(bus.OUT_total), 0);
    chk({tag, "_count"}, int'(bus.OUT_count), 0);
    chk({tag, "_ovf"}, int'(bus.OUT_ovf), 0);
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.OUT_valid && bus.IN_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got total %0d count %0d, expected none (t=%0t)",
                 bus.OUT_total, bus.OUT_count, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_total", int'(bus.OUT_total), int'(mon_e.total));
        chk("result_count", int'(bus.OUT_count), int'(mon_e.count));
        chk("result_ovf", int'(bus.OUT_ovf), int'(mon_e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.IN_valid = 1'b0;
    bus.IN_sum   = '0;
    bus.IN_last  = 1'b0;
    bus.IN_ready = 1'b1;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", int'(bus.OUT_ready), 1);

    // Full batch, back to back.
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b0);
    beat(8'd30, 1'b0);
    push_exp(100, 4, 1'b0);
    beat(8'd40, 1'b0);
    chk("full_latency_valid", int'(bus.OUT_valid), 1);
    chk("full_done_ready", int'(bus.OUT_ready), 0);
    gap(1);
    chk("full_idle_valid", int'(bus.OUT_valid), 0);
    chk("full_idle_ready", int'(bus.OUT_ready), 1);

    // Short batch, then IN_last coinciding with the COUNT-th beat.
    beat(8'd7, 1'b0);
    push_exp(16, 2, 1'b0);
    beat(8'd9, 1'b1);
    chk("short_latency_valid", int'(bus.OUT_valid), 1);
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b0);
    push_exp(10, 4, 1'b0);
    beat(8'd4, 1'b1);
    gap(3);
    chk("single_term_queue", exp_q.size(), 0);

    // Backpressure: DONE must hold and refuse offered beats.
    bus.IN_ready = 1'b0;
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    push_exp(4, 4, 1'b0);
    beat(8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.IN_valid = 1'b1;
      bus.IN_sum   = 8'd99;
      @(negedge clk);
      chk("bp_valid", int'(bus.OUT_valid), 1);
      chk("bp_total", int'(bus.OUT_total), 4);
      chk("bp_count", int'(bus.OUT_count), 4);
      chk("bp_ready", int'(bus.OUT_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.IN_valid = 1'b0;
    bus.IN_ready = 1'b1;
    gap(1);
    chk("bp_released_valid", int'(bus.OUT_valid), 0);

    // Overflow on carry-out.
    beat(8'd200, 1'b0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    push_exp(255, 2, 1'b1);
`else
    push_exp(44, 2, 1'b1);
`endif
    beat(8'd100, 1'b1);
    gap(1);

    // Bubbles between beats.
    beat(8'd1, 1'b0);
    gap(1);
    beat(8'd2, 1'b0);
    gap(2);
    beat(8'd3, 1'b0);
    push_exp(10, 4, 1'b0);
    beat(8'd4, 1'b0);
    gap(1);

    // Reset mid-batch discards the partial sum.
    beat(8'd5, 1'b0);
    beat(8'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", int'(bus.OUT_ready), 1);
    beat(8'd5, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd5, 1'b0);
    push_exp(20, 4, 1'b0);
    beat(8'd5, 1'b0);

    gap(5);
    chk("drain_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
